// File: rtl/timer_device.sv
// rtl/timer_device.sv - programmable down-counting timer with one-shot/auto-reload modes and interrupt
module timer_device (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:2] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        LOAD = 2'b01,
        CNT  = 2'b10,
        INT  = 2'b11
    } state_t;

    state_t      state_q, state_d;
    logic        en_q, en_d;
    logic [1:0]  mode_q, mode_d;
    logic        im_q, im_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;

    logic        wr_ctrl;
    logic        wr_preset;
    logic        en_eff;
    logic        auto_reload;

    // The bridge only strobes WE on a device hit, so the upper address bits carry no decode.
    logic unused_addr_bits;
    assign unused_addr_bits = ^Addr[31:4];

    assign wr_ctrl     = WE && (Addr[3:2] == 2'b00);
    assign wr_preset   = WE && (Addr[3:2] == 2'b01);
    // A CTRL write in the same cycle decides whether counting continues past this edge.
    assign en_eff      = wr_ctrl ? Din[0] : en_q;
    // Mode 1x behaves as one-shot.
    assign auto_reload = (mode_q == 2'b01);

    // State and register update, cleared asynchronously by reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            en_q       <= 1'b0;
            mode_q     <= 2'b00;
            im_q       <= 1'b0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            en_q       <= en_d;
            mode_q     <= mode_d;
            im_q       <= im_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
        end
    end

    // Next-state logic: FSM actions first, then bus writes, which win over the FSM.
    always_comb begin
        state_d    = state_q;
        en_d       = en_q;
        mode_d     = mode_q;
        im_d       = im_q;
        preset_d   = preset_q;
        count_d    = count_q;
        irq_flag_d = irq_flag_q;

        case (state_q)
            IDLE: begin
                if (en_q) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                count_d = preset_q;
                state_d = CNT;
            end
            CNT: begin
                if (!en_eff) begin
                    state_d = IDLE;
                end else if (count_q > 32'd1) begin
                    count_d = count_q - 32'd1;
                end else begin
                    count_d    = 32'd0;
                    irq_flag_d = 1'b1;
                    state_d    = INT;
                end
            end
            INT: begin
                if (auto_reload) begin
                    irq_flag_d = 1'b0;
                end else begin
                    en_d = 1'b0;
                end
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (wr_ctrl) begin
            en_d       = Din[0];
            mode_d     = Din[2:1];
            im_d       = Din[3];
            irq_flag_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d   = Din;
            irq_flag_d = 1'b0;
        end
    end

    // Read mux; COUNT and the unused slot are not writable, slot 11 reads zero.
    always_comb begin
        Dout = 32'd0;
        case (Addr[3:2])
            2'b00:   Dout = {28'd0, im_q, mode_q, en_q};
            2'b01:   Dout = preset_q;
            2'b10:   Dout = count_q;
            default: Dout = 32'd0;
        endcase
    end

    assign IRQ = im_q & irq_flag_q;

endmodule

// File: tb/tb_timer_device.sv
// tb/tb_timer_device.sv - randomized and directed self-checking bench for timer_device
`timescale 1ns/1ps
module tb_timer_device;

    logic        clk;
    logic        reset;
    logic [31:2] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic        IRQ;

    int total;
    int bad;

    localparam logic [31:2] BASE = 30'h1FC0;

    timer_device dut (
        .clk  (clk),
        .reset(reset),
        .Addr (Addr),
        .WE   (WE),
        .Din  (Din),
        .Dout (Dout),
        .IRQ  (IRQ)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Reference model: timer phases 0 idle, 1 loading, 2 counting, 3 expired.
    logic        m_en;
    logic [1:0]  m_mode;
    logic        m_im;
    logic [31:0] m_preset;
    logic [31:0] m_count;
    logic        m_irq;
    int          m_ph;

    logic [31:0] obs [4];
    logic        obs_irq;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en = 0; m_mode = 0; m_im = 0; m_preset = 0; m_count = 0; m_irq = 0; m_ph = 0;
    endtask

    function automatic logic [31:0] model_rd(input int a);
        case (a)
            0: return {28'd0, m_im, m_mode, m_en};
            1: return m_preset;
            2: return m_count;
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_edge(input logic we, input int a, input logic [31:0] din);
        bit wc, wp, keep_going;
        wc = we && (a == 0);
        wp = we && (a == 1);
        case (m_ph)
            0: if (m_en) m_ph = 1;
            1: begin m_count = m_preset; m_ph = 2; end
            2: begin
                keep_going = wc ? din[0] : m_en;
                if (!keep_going) m_ph = 0;
                else if (m_count > 1) m_count = m_count - 1;
                else begin m_count = 0; m_irq = 1; m_ph = 3; end
            end
            default: begin
                if (m_mode == 2'b01) m_irq = 0;
                else m_en = 0;
                m_ph = 0;
            end
        endcase
        if (wc) begin
            m_en = din[0]; m_mode = din[2:1]; m_im = din[3]; m_irq = 0;
        end
        if (wp) begin
            m_preset = din; m_irq = 0;
        end
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < 4; a++) begin
            Addr = BASE | 30'(a);
            #1;
            obs[a] = Dout;
            check_eq(tag, Dout, model_rd(a));
        end
        obs_irq = IRQ;
        check_eq({tag, "_irq"}, {31'd0, IRQ}, {31'd0, m_im & m_irq});
    endtask

    task automatic step(input logic we, input int a, input logic [31:0] din);
        WE   = we;
        Addr = BASE | 30'(a);
        Din  = din;
        @(posedge clk);
        model_edge(we, a, din);
        #1;
        WE = 1'b0;
        sweep("rd");
    endtask

    task automatic async_reset();
        #1;
        reset = 1'b0;
        model_reset();
        sweep("rst");
        #1;
        reset = 1'b1;
    endtask

    initial begin
        int n, k, w, p, exp_lat;
        logic [31:0] d;
        total = 0;
        bad   = 0;
        reset = 1'b0;
        WE    = 1'b0;
        Addr  = BASE;
        Din   = 32'd0;
        model_reset();
        #3;
        sweep("reset_state");
        #10;
        reset = 1'b1;

        // One-shot latency for several presets, including 0 and 1.
        for (int t = 0; t < 5; t++) begin
            n = (t < 4) ? t : 3;
            exp_lat = ((n < 1) ? 1 : n) + 2;
            step(1, 1, n);
            step(1, 0, 32'h9);
            k = 0;
            while (!obs_irq && k < 40) begin
                step(0, 0, 0);
                k++;
            end
            check_eq("oneshot_latency", k, exp_lat);
            step(0, 0, 0);
            check_eq("oneshot_ctrl", obs[0], 32'h8);
            check_eq("oneshot_hold", {31'd0, obs_irq}, 32'd1);
            if (t == 4) begin
                async_reset();
                check_eq("rst_irq", {31'd0, obs_irq}, 32'd0);
                check_eq("rst_ctrl", obs[0], 32'd0);
                step(0, 0, 0);
                step(0, 0, 0);
                check_eq("rst_stays_idle", obs[2], 32'd0);
            end else begin
                step(1, 0, 32'h8);
                check_eq("oneshot_clear", {31'd0, obs_irq}, 32'd0);
            end
        end

        // Auto-reload pulse width and period.
        for (int t = 0; t < 4; t++) begin
            n = t + ((t == 3) ? 2 : 0);
            step(1, 1, n);
            step(1, 0, 32'hB);
            k = 0;
            while (!obs_irq && k < 40) begin step(0, 0, 0); k++; end
            w = 0;
            while (obs_irq && w < 40) begin step(0, 0, 0); w++; end
            p = w;
            while (!obs_irq && p < 40) begin step(0, 0, 0); p++; end
            check_eq("auto_width", w, 1);
            check_eq("auto_period", p, ((n < 1) ? 1 : n) + 3);
            check_eq("auto_ctrl", obs[0], 32'hB);
            step(1, 0, 32'h0);
        end

        // Masked expiry.
        step(1, 1, 1);
        step(1, 0, 32'h1);
        for (int i = 0; i < 5; i++) step(0, 0, 0);
        check_eq("masked_count", obs[2], 32'd0);
        check_eq("masked_irq", {31'd0, obs_irq}, 32'd0);

        // Pause at 5, then restart from a new preset.
        step(1, 1, 9);
        step(1, 0, 32'h1);
        k = 0;
        while (!(m_ph == 2 && m_count == 5) && k < 40) begin step(0, 0, 0); k++; end
        step(1, 0, 32'h0);
        for (int i = 0; i < 3; i++) step(0, 0, 0);
        check_eq("pause_frozen", obs[2], 32'd5);
        step(1, 1, 7);
        step(1, 0, 32'h1);
        step(0, 0, 0);
        step(0, 0, 0);
        check_eq("restart_count", obs[2], 32'd7);

        // Writes to COUNT and to the unused slot are ignored.
        step(1, 2, 32'h1234);
        step(1, 3, 32'h1234);
        check_eq("unused_slot", obs[3], 32'd0);
        step(1, 0, 32'h0);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            p = $urandom_range(0, 99);
            d = $urandom;
            if (p < 8)       step(1, 0, {d[31:4], 4'($urandom_range(0, 15))});
            else if (p < 14) step(1, 1, $urandom_range(0, 5));
            else if (p < 17) step(1, 2, d);
            else if (p < 20) step(1, 3, d);
            else if (p < 22) async_reset();
            else             step(0, 0, d);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end

endmodule

// File: doc/timer_device.md
TIMER_DEVICE -- requirements
Module: timer_device

Interface
REQ-001 The block SHALL have these ports (clock and reset first): clk  input  1  system clock; all state changes on rising edge.
REQ-002 reset  input  1  asynchronous, active-low; low forces reset state immediately, independent of clk.
REQ-003 Addr  input  30  word address bits [31:2] from the data-memory stage; only Addr[3:2] are decoded, because the bus bridge asserts WE only on a 0x7F00-0x7F0B hit.
REQ-004 WE  input  1  word write strobe, qualified by the bridge with the device hit and no exception.
REQ-005 Din  input  32  write data.
REQ-006 Dout  output  32  combinational read data for the register selected by Addr[3:2].
REQ-007 IRQ  output  1  interrupt request to the CP0 interrupt pending input.
REQ-008 Register map: 0x7F00 CTRL, 0x7F04 PRESET, 0x7F08 COUNT, with Addr[3:2]=00, 01 and 10 respectively; Addr[3:2]=11 reads 0 and ignores writes.
REQ-009 CTRL fields: [0] Enable, [2:1] Mode (00 one-shot, 01 auto-reload, 1x treated as 00), [3] IM (interrupt mask); [31:4] read as 0 and ignore writes.

Function
REQ-010 The FSM SHALL have 4 states: IDLE, LOAD, CNT, INT.
REQ-011 IDLE: Enable=1 SHALL go to LOAD; otherwise stay in IDLE.
REQ-012 LOAD: COUNT<=PRESET, then go to CNT, in one cycle and unconditionally.
REQ-013 CNT with Enable=0: go to IDLE with COUNT held.
REQ-014 CNT with COUNT>1: decrement COUNT.
REQ-015 CNT with COUNT<=1: COUNT<=0, set irq_flag and go to INT.
REQ-016 INT in Mode 00: clear Enable and go to IDLE; irq_flag stays set.
REQ-017 INT in Mode 01: go to IDLE with Enable kept; irq_flag is cleared on this edge, so it is high for exactly one cycle.
REQ-018 IRQ SHALL be IM & irq_flag, combinationally.
REQ-019 A write to CTRL or PRESET SHALL clear irq_flag on that edge.
REQ-020 A write to CTRL SHALL take precedence over the FSM's Enable clear in the same cycle.
REQ-021 Writes to COUNT SHALL be ignored, since the data-memory stage raises ExcCode 5 for them.
REQ-022 A PRESET write during CNT SHALL NOT alter COUNT; it takes effect at the next LOAD.
REQ-023 A CTRL write setting Enable=0 during CNT SHALL make the next state IDLE, with COUNT frozen and readable.
REQ-024 Re-enabling from IDLE SHALL always pass through LOAD, so the count restarts from PRESET.
REQ-025 PRESET=0 and PRESET=1 SHALL behave identically: INT is entered one edge after LOAD.
REQ-026 Latency for PRESET=N>=1: with Enable written at edge E0, COUNT=N after E2 and INT is entered at edge E(N+2).
REQ-027 The auto-reload period SHALL be N+3 cycles.
REQ-028 Dout SHALL reflect register state after the most recent edge; there is no read side effect.
REQ-029 Arithmetic SHALL be 32-bit unsigned; COUNT never wraps below 0.

Reset
REQ-030 While reset=0, state SHALL be IDLE and CTRL, PRESET, COUNT and irq_flag SHALL be 0.
REQ-031 Consequently IRQ=0 and Dout=0 for every address during reset.
REQ-032 Reset asserted mid-count SHALL abort immediately; the device stays idle until CTRL is written with Enable=1 after release.

Verification
REQ-033 Scenario one-shot: PRESET=3, then CTRL=0x9 at E0 -> COUNT reads 3,2,1 after E2..E4, 0 plus IRQ=1 after E5; CTRL reads 0x8 after E6; IRQ held high until a CTRL write clears it.
REQ-034 Scenario auto-reload: PRESET=2, CTRL=0xB -> IRQ pulses high for exactly 1 cycle every 5 cycles; CTRL stays 0xB.
REQ-035 Scenario masked: CTRL=0x1 with PRESET=1 -> INT reached and COUNT=0, but IRQ stays 0 throughout.
REQ-036 Scenario pause and restart: CTRL=0x0 written while COUNT=5 -> COUNT frozen at 5. Then PRESET=7 and CTRL=0x1 -> COUNT=7 two edges later.
REQ-037 Scenario illegal writes: write 0x1234 to 0x7F08 and to Addr[3:2]=11 -> COUNT and all registers unchanged; 0x7F0C reads 0.
REQ-038 Scenario async reset: drive reset=0 between clock edges mid-CNT with IRQ=1 -> IRQ, COUNT and CTRL read 0 before the next edge.
